// File: rtl/pu_msp430_clock_switch_ctrl.sv
// Clock-switch sequencer for the glitch-free two-input clock mux: waits for osc1 ready/settle, holds the handoff, reports done/timeout.
// Optional fail-safe fallback to clk_in0 on loss of osc1_ready is enabled by defining PU_MSP430_CLOCK_FAILSAFE_EN.
module pu_msp430_clock_switch_ctrl #(
  parameter int SETTLE_W    = 8,
  parameter int TIMEOUT_W   = 12,
  parameter int HANDOFF_CYC = 4
) (
  input  logic                mclk,
  input  logic                reset,
  input  logic                sw_req,
  input  logic                sw_sel,
  input  logic [SETTLE_W-1:0] sw_settle,
  input  logic                osc1_ready,
  input  logic                scan_mode,
  output logic                selection,
  output logic                cur_sel,
  output logic                busy,
  output logic                sw_done,
  output logic                sw_err,
  output logic                osc_fault
);

  localparam int HW = (HANDOFF_CYC > 1) ? $clog2(HANDOFF_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    SETTLE   = 2'd2,
    SWITCH   = 2'd3
  } state_t;

  state_t               r_state, w_state;
  logic                 r_target, w_target;
  logic [SETTLE_W-1:0]  r_cap, w_cap;
  logic [SETTLE_W-1:0]  r_cnt, w_cnt;
  logic [TIMEOUT_W-1:0] r_tcnt, w_tcnt;
  logic [TIMEOUT_W-1:0] w_tcnt_inc;
  logic [HW-1:0]        r_hcnt, w_hcnt;
  logic                 r_sel, w_sel;
  logic                 r_cur, w_cur;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 r_err, w_err;
  logic                 r_fault, w_fault;
  logic                 w_lost;
  logic                 w_fs_fire;

  assign w_tcnt_inc = r_tcnt + 1'b1;

`ifdef PU_MSP430_CLOCK_FAILSAFE_EN
  // r_lost remembers that osc1_ready was already low on the previous IDLE cycle.
  logic r_lost;

  always_ff @(posedge mclk) begin
    if (reset) r_lost <= 1'b0;
    else       r_lost <= w_lost;
  end

  always_comb begin
    w_lost    = 1'b0;
    w_fs_fire = 1'b0;
    if (r_state == IDLE && r_cur && !osc1_ready) begin
      w_lost    = ~r_lost;
      w_fs_fire = r_lost;
    end
  end
`else
  assign w_lost    = 1'b0;
  assign w_fs_fire = 1'b0;
`endif

  always_comb begin
    w_state  = r_state;
    w_target = r_target;
    w_cap    = r_cap;
    w_cnt    = r_cnt;
    w_tcnt   = r_tcnt;
    w_hcnt   = r_hcnt;
    w_sel    = r_sel;
    w_cur    = r_cur;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_err    = r_err;
    w_fault  = r_fault;
    case (r_state)
      IDLE: begin
        if (w_fs_fire) begin
          w_sel   = 1'b0;
          w_cur   = 1'b0;
          w_fault = 1'b1;
        end else if (sw_req && !scan_mode) begin
          w_target = sw_sel;
          w_cap    = sw_settle;
          w_cnt    = sw_settle;
          w_err    = 1'b0;
          w_fault  = 1'b0;
          if (sw_sel == r_cur) begin
            w_done = 1'b1;
          end else if (!sw_sel) begin
            w_state = SWITCH;
            w_busy  = 1'b1;
            w_sel   = 1'b0;
            w_hcnt  = '0;
          end else begin
            w_state = WAIT_RDY;
            w_busy  = 1'b1;
            w_tcnt  = '0;
          end
        end
      end
      WAIT_RDY: begin
        if (osc1_ready) begin
          w_state = SETTLE;
          w_cnt   = r_cap;
        end else begin
          w_tcnt = w_tcnt_inc;
          if (&w_tcnt_inc) begin
            w_err   = 1'b1;
            w_busy  = 1'b0;
            w_state = IDLE;
          end
        end
      end
      SETTLE: begin
        // A ready dropout restarts the wait; the timeout budget keeps running.
        if (!osc1_ready) begin
          w_state = WAIT_RDY;
        end else if (r_cnt == '0) begin
          w_state = SWITCH;
          w_sel   = r_target;
          w_hcnt  = '0;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      SWITCH: begin
        if (r_hcnt == HW'(HANDOFF_CYC - 1)) begin
          w_cur   = r_target;
          w_done  = 1'b1;
          w_busy  = 1'b0;
          w_state = IDLE;
        end else begin
          w_hcnt = r_hcnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_target <= 1'b0;
      r_cap    <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_hcnt   <= '0;
      r_sel    <= 1'b0;
      r_cur    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_target <= w_target;
      r_cap    <= w_cap;
      r_cnt    <= w_cnt;
      r_tcnt   <= w_tcnt;
      r_hcnt   <= w_hcnt;
      r_sel    <= w_sel;
      r_cur    <= w_cur;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
      r_fault  <= w_fault;
    end
  end

  assign selection = r_sel;
  assign cur_sel   = r_cur;
  assign busy      = r_busy;
  assign sw_done   = r_done;
  assign sw_err    = r_err;
  assign osc_fault = r_fault;

endmodule

// File: doc/pu_msp430_clock_switch_ctrl.md
Name: pu_msp430_clock_switch_ctrl

Overview:
- Sequencer that drives the `selection` input of the glitch-free two-input clock mux.
- Accepts software switch requests and, before switching to clk_in1, waits for the secondary oscillator to report ready and then to stay stable for a programmable time.
- Holds each new selection for a fixed handoff window, then reports completion or timeout.
- Sits in the clock module next to the mux. It is clocked by the free-running primary-source clock, so it keeps running while the mux output changes.

Parameters:
- SETTLE_W, 8: width of the programmable settle count.
- TIMEOUT_W, 12: width of the oscillator-ready timeout counter; timeout is 2^TIMEOUT_W-1 cycles.
- HANDOFF_CYC, 4: cycles `selection` is held before completion is reported (≥1).

Ports:
- mclk  input  1  free-running controller clock (primary source domain).
- reset  input  1  synchronous active-high reset.
- sw_req  input  1  one-cycle switch request strobe.
- sw_sel  input  1  requested source (0=clk_in0, 1=clk_in1); sampled with sw_req.
- sw_settle  input  SETTLE_W  stable-cycle count; sampled with sw_req.
- osc1_ready  input  1  clk_in1 oscillator ready, already synchronized to mclk.
- scan_mode  input  1  scan mode; blocks request acceptance.
- selection  output  1  drives the clock mux select.
- cur_sel  output  1  committed current source.
- busy  output  1  sequence in progress.
- sw_done  output  1  one-cycle completion pulse.
- sw_err  output  1  sticky timeout flag.
- osc_fault  output  1  sticky fail-safe flag (optional feature).

Behaviour:
- Interface is decided as: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, all counters 0. Reset mid-sequence restores these on the next edge.
- States: IDLE, WAIT_RDY, SETTLE, SWITCH.
- IDLE, request acceptance:
  - A request is accepted when sw_req=1 and scan_mode=0.
  - On acceptance: capture target=sw_sel and cnt=sw_settle, clear sw_err and osc_fault.
  - target==cur_sel: sw_done pulses next cycle; busy stays 0; no state change.
  - target=0: go to SWITCH, busy=1.
  - target=1: go to WAIT_RDY, busy=1, timeout counter cleared.
- sw_req while busy=1 or scan_mode=1 is ignored (no queuing).
- WAIT_RDY:
  - osc1_ready=1: go to SETTLE and load the settle counter with the captured count.
  - Otherwise the timeout counter increments. When it reaches all-ones: sw_err=1, busy=0, return to IDLE; selection and cur_sel unchanged; no sw_done.
- SETTLE:
  - The counter decrements each cycle; on the cycle it is 0 the FSM goes to SWITCH. SETTLE therefore lasts captured count + 1 cycles (count 0 → 1 cycle).
  - osc1_ready falling in SETTLE returns the FSM to WAIT_RDY. The timeout counter is not cleared.
- SWITCH:
  - selection=target from entry.
  - Held for HANDOFF_CYC cycles, then cur_sel<=target, sw_done=1 for one cycle, busy=0, IDLE.
- Latency, request sampled at edge 0:
  - Switch to 1, osc ready, settle N: selection rises after edge N+2; sw_done after edge N+2+HANDOFF_CYC.
  - Switch to 0: selection falls after edge 0; sw_done after edge HANDOFF_CYC.
- `selection` changes only on entry to SWITCH, or via the fail-safe path.

Optional Feature:
- Macro PU_MSP430_CLOCK_FAILSAFE_EN.
- Defined:
  - In IDLE with cur_sel=1, osc1_ready low for 2 consecutive cycles forces selection=0 and cur_sel=0 on the next edge, and sets osc_fault=1.
  - osc_fault stays set until reset or an accepted request; no sw_done is generated.
  - If fail-safe and a request coincide, fail-safe wins and the request is ignored.
- Not defined: osc_fault is tied 0 and a loss of osc1_ready after switching is ignored.

Test Plan:
- Reset, then sw_req, sw_sel=1, sw_settle=3, osc1_ready=1 (defaults): selection=1 after edge 5, sw_done pulse after edge 9, cur_sel=1, busy high edges 1–9.
- From cur_sel=1, request sw_sel=0: selection=0 after edge 0; sw_done after edge 4; cur_sel=0.
- Request sw_sel=1 with osc1_ready held 0: sw_err=1 and busy=0 after 4095 WAIT_RDY cycles; selection stays 0. A later accepted request clears sw_err.
- osc1_ready drops for 1 cycle mid-SETTLE (sw_settle=10): FSM returns to WAIT_RDY, then recovers; settle restarts with the full count of 10; sw_done timing shifts accordingly.
- Request same as cur_sel → sw_done next cycle, busy never 1. sw_req during busy → ignored. sw_req with scan_mode=1 → ignored. Reset mid-SETTLE → all outputs 0 next cycle.
- FAILSAFE_EN defined, cur_sel=1 in IDLE, osc1_ready low 2 cycles: selection=0, cur_sel=0, osc_fault=1. Same stimulus with the macro undefined: no change.
